// File: rtl/seq_divider_6by3.sv
// 6-bit by 3-bit sequential restoring divider, one quotient bit per cycle.
// Optional DIV_ZERO_CHECK_EN: zero divisor finishes in one cycle and flags div_by_zero.
module seq_divider_6by3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] dividend,
    input  logic [2:0] divisor,
    output logic [5:0] quotient,
    output logic [2:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0] state;
    logic [5:0] dvd_q;
    logic [5:0] quo_q;
    logic [2:0] dvs_q;
    logic [2:0] cnt_q;
    logic [3:0] rem_q;
    logic [3:0] trial;
    logic [3:0] rem_nxt;
    logic       take;

`ifdef DIV_ZERO_CHECK_EN
    logic dbz_q;
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

    // Shift the next dividend bit into the partial remainder and try a subtract.
    always_comb begin
        trial   = {rem_q[2:0], dvd_q[5]};
        take    = (trial >= {1'b0, dvs_q});
        rem_nxt = take ? (trial - {1'b0, dvs_q}) : trial;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            dvd_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
`ifdef DIV_ZERO_CHECK_EN
            dbz_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
`ifdef DIV_ZERO_CHECK_EN
                        if (divisor == 3'd0) begin
                            state     <= S_DONE;
                            quotient  <= 6'h3F;
                            remainder <= 3'd0;
                            dbz_q     <= 1'b1;
                        end else
`endif
                        begin
                            state <= S_RUN;
                            dvd_q <= dividend;
                            dvs_q <= divisor;
                            rem_q <= '0;
                            quo_q <= '0;
                            cnt_q <= '0;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    dvd_q <= {dvd_q[4:0], 1'b0};
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[4:0], take};
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd5) begin
                        state     <= S_DONE;
                        quotient  <= {quo_q[4:0], take};
                        remainder <= rem_nxt[2:0];
`ifdef DIV_ZERO_CHECK_EN
                        dbz_q     <= 1'b0;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_6by3.sv
// Self-checking bench for seq_divider_6by3 against integer / and % reference.
// Honours DIV_ZERO_CHECK_EN for the zero-divisor expectations.
module tb_seq_divider_6by3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] dividend;
    logic [2:0] divisor;
    logic [5:0] quotient;
    logic [2:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;

    seq_divider_6by3 dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic, with the zero-divisor rules.
    task automatic ref_div(input int a, input int b, output int q, output int r,
                           output int z, output int lat);
        if (b != 0) begin
            q = a / b; r = a % b; z = 0; lat = 7;
        end else begin
`ifdef DIV_ZERO_CHECK_EN
            q = 63; r = 0; z = 1; lat = 1;
`else
            q = 63; r = a % 8; z = 0; lat = 7;
`endif
        end
    endtask

    // Issue one division, scramble inputs afterwards, check timing and results.
    task automatic run_div(input int a, input int b, input string name);
        int q, r, z, lat, k, bcnt;
        ref_div(a, b, q, r, z, lat);
        start = 1'b1;
        dividend = 6'(a);
        divisor = 3'(b);
        tick();
        start = 1'b0;
        dividend = 6'($urandom());
        divisor = 3'($urandom());
        k = 1;
        bcnt = 0;
        while (!done && k < 20) begin
            if (busy) bcnt++;
            tick();
            k++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: done=%b after %0d cycles, want 1", name, done, k);
        end
        checks++;
        if (k != lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, k, lat);
        end
        checks++;
        if (bcnt != lat - 1) begin
            errors++;
            $display("FAIL %s busy cycles: got %0d want %0d", name, bcnt, lat - 1);
        end
        checks++;
        if (quotient !== 6'(q)) begin
            errors++;
            $display("FAIL %s quotient (%0d/%0d): got %0d want %0d", name, a, b, quotient, q);
        end
        checks++;
        if (remainder !== 3'(r)) begin
            errors++;
            $display("FAIL %s remainder (%0d/%0d): got %0d want %0d", name, a, b, remainder, r);
        end
        checks++;
        if (div_by_zero !== 1'(z)) begin
            errors++;
            $display("FAIL %s div_by_zero: got %b want %0d", name, div_by_zero, z);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        dividend = 6'd45;
        divisor = 3'd6;
        tick();
        tick();
        checks++;
        if ({quotient, remainder, busy, done, div_by_zero} !== 12'd0) begin
            errors++;
            $display("FAIL reset outputs: got q=%0d r=%0d b=%b d=%b z=%b want all 0",
                     quotient, remainder, busy, done, div_by_zero);
        end
    endtask

    // Releases reset on the same edge that accepts start.
    task automatic test_basic();
        rst = 1'b0;
        run_div(45, 6, "basic_45_6");
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b busy=%b want 0 0", done, busy);
        end
        checks++;
        if (quotient !== 6'd7 || remainder !== 3'd3) begin
            errors++;
            $display("FAIL hold: got q=%0d r=%0d want 7 3", quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        start = 1'b1;
        dividend = 6'd63;
        divisor = 3'd7;
        tick();
        dividend = 6'd5;
        for (k = 1; k < 7; k++) tick();
        checks++;
        if (done !== 1'b1 || quotient !== 6'd9 || remainder !== 3'd0) begin
            errors++;
            $display("FAIL b2b first: got d=%b q=%0d r=%0d want 1 9 0", done, quotient, remainder);
        end
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b gap: got busy=%b want 1", busy);
        end
        for (k = 8; k < 14; k++) tick();
        checks++;
        if (done !== 1'b1 || quotient !== 6'd0 || remainder !== 3'd5) begin
            errors++;
            $display("FAIL b2b second: got d=%b q=%0d r=%0d want 1 0 5", done, quotient, remainder);
        end
        tick();
    endtask

    task automatic test_ignore_start();
        int k, pulses, at;
        start = 1'b1;
        dividend = 6'd20;
        divisor = 3'd3;
        tick();
        start = 1'b0;
        pulses = 0;
        at = 0;
        for (k = 1; k < 16; k++) begin
            if (done) begin pulses++; at = k; end
            if (k == 3) begin start = 1'b1; dividend = 6'd63; divisor = 3'd1; end
            else start = 1'b0;
            if (at == k) begin
                checks++;
                if (quotient !== 6'd6 || remainder !== 3'd2) begin
                    errors++;
                    $display("FAIL ignore result: got q=%0d r=%0d want 6 2", quotient, remainder);
                end
            end
            tick();
        end
        checks++;
        if (pulses != 1 || at != 7) begin
            errors++;
            $display("FAIL ignore pulses: got %0d at %0d want 1 at 7", pulses, at);
        end
    endtask

    task automatic test_abort();
        int k, seen;
        start = 1'b1;
        dividend = 6'd50;
        divisor = 3'd4;
        tick();
        start = 1'b0;
        for (k = 1; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({quotient, remainder, busy, done, div_by_zero} !== 12'd0) begin
            errors++;
            $display("FAIL abort outputs: got q=%0d r=%0d b=%b d=%b want all 0",
                     quotient, remainder, busy, done);
        end
        seen = 0;
        for (k = 0; k < 10; k++) begin
            if (done || busy) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort quiet: got %0d active cycles want 0", seen);
        end
        run_div(50, 4, "abort_rerun");
    endtask

    task automatic test_div_zero();
        tick();
        run_div(13, 0, "div_zero");
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 64; a++) begin
            for (int b = 1; b < 8; b++) begin
                int gap = int'($urandom_range(2, 0));
                for (int g = 0; g < gap; g++) tick();
                run_div(a, b, "sweep");
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_ignore_start();
        test_abort();
        test_div_zero();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
